fc7_weight_reader: RTL and testbench

Reader and compute controller for the F7 fully-connected layer (84 inputs, 10 outputs) of the LeNet datapath. It sequences w7_raddr into the w7 weight ROM and x_raddr into the F6 activation buffer. It runs ten signed MACs in parallel, one per output neuron, using the ten 8-bit weight lanes. It then streams the ten accumulated scores one per cycle to the downstream argmax/output stage.

---
 rtl/fc7_weight_reader_if.sv | 45 ++++
 rtl/fc7_weight_reader.sv | 162 ++++++++++++++++
 tb/tb_fc7_weight_reader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fc7_weight_reader_if.sv
// Bus bundle for the F7 weight reader: start/status, weight ROM and
// activation buffer read ports, and the result beat stream.
interface fc7_weight_reader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] w7_raddr;
    logic [DATA_W-1:0] w7_1_rdata;
    logic [DATA_W-1:0] w7_2_rdata;
    logic [DATA_W-1:0] w7_3_rdata;
    logic [DATA_W-1:0] w7_4_rdata;
    logic [DATA_W-1:0] w7_5_rdata;
    logic [DATA_W-1:0] w7_6_rdata;
    logic [DATA_W-1:0] w7_7_rdata;
    logic [DATA_W-1:0] w7_8_rdata;
    logic [DATA_W-1:0] w7_9_rdata;
    logic [DATA_W-1:0] w7_10_rdata;
    logic [ADDR_W-1:0] x_raddr;
    logic [DATA_W-1:0] x_rdata;
    logic              res_valid;
    logic [3:0]        res_idx;
    logic [ACC_W-1:0]  res_data;

    // Controller side: drives addresses, status and results.
    modport master (
        input  start,
        input  w7_1_rdata, w7_2_rdata, w7_3_rdata, w7_4_rdata, w7_5_rdata,
        input  w7_6_rdata, w7_7_rdata, w7_8_rdata, w7_9_rdata, w7_10_rdata,
        input  x_rdata,
        output busy, done, w7_raddr, x_raddr, res_valid, res_idx, res_data
    );

    // Memory/consumer side.
    modport slave (
        output start,
        output w7_1_rdata, w7_2_rdata, w7_3_rdata, w7_4_rdata, w7_5_rdata,
        output w7_6_rdata, w7_7_rdata, w7_8_rdata, w7_9_rdata, w7_10_rdata,
        output x_rdata,
        input  busy, done, w7_raddr, x_raddr, res_valid, res_idx, res_data
    );
endinterface

// File: rtl/fc7_weight_reader.sv
// F7 fully-connected layer controller: walks N_IN weight/activation rows,
// runs ten parallel signed MACs and streams the ten scores out one per cycle.
module fc7_weight_reader #(
    parameter int N_IN   = 84,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    fc7_weight_reader_if.master bus
);
    localparam int                N_OUT    = 10;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_IN - 1);
    localparam logic [3:0]        LAST_IDX = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // One MAC term: full-width signed product, sign-extended to the accumulator.
    function automatic logic signed [ACC_W-1:0] mac_term(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] p;
        p = a * b;
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_W-1:0]         r_addr;
    logic [ADDR_W-1:0]         w_addr_nxt;
    logic                      r_rv;
    logic signed [DATA_W-1:0]  w_wt [N_OUT];
    logic signed [DATA_W-1:0]  w_x;
    logic signed [ACC_W-1:0]   r_acc [N_OUT];
    logic signed [ACC_W-1:0]   w_acc_nxt [N_OUT];
    logic                      r_busy, w_busy_nxt;
    logic                      r_done, w_done_nxt;
    logic                      r_res_valid, w_res_valid_nxt;
    logic [3:0]                r_res_idx, w_res_idx_nxt;
    logic [ACC_W-1:0]          r_res_data, w_res_data_nxt;

    assign w_wt[0] = bus.w7_1_rdata;
    assign w_wt[1] = bus.w7_2_rdata;
    assign w_wt[2] = bus.w7_3_rdata;
    assign w_wt[3] = bus.w7_4_rdata;
    assign w_wt[4] = bus.w7_5_rdata;
    assign w_wt[5] = bus.w7_6_rdata;
    assign w_wt[6] = bus.w7_7_rdata;
    assign w_wt[7] = bus.w7_8_rdata;
    assign w_wt[8] = bus.w7_9_rdata;
    assign w_wt[9] = bus.w7_10_rdata;
    assign w_x     = bus.x_rdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_FETCH; else w_state_nxt = S_IDLE;
            S_FETCH: if (r_addr == LAST_ROW) w_state_nxt = S_DRAIN; else w_state_nxt = S_FETCH;
            S_DRAIN: w_state_nxt = S_OUT;
            S_OUT:   if (r_res_idx == LAST_IDX) w_state_nxt = S_DONE; else w_state_nxt = S_OUT;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Accumulator update: add this cycle's product whenever returned data is valid.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            w_acc_nxt[k] = r_acc[k];
            if (r_rv) begin
                w_acc_nxt[k] = r_acc[k] + mac_term(w_wt[k], w_x);
            end else begin
                w_acc_nxt[k] = r_acc[k];
            end
        end
    end

    // Output/next-value logic, decoded from the upcoming state so every output is registered.
    always_comb begin
        w_addr_nxt      = '0;
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = (w_state_nxt == S_DONE);
        w_res_valid_nxt = (w_state_nxt == S_OUT);
        w_res_idx_nxt   = 4'd0;
        w_res_data_nxt  = '0;
        if (r_state == S_FETCH && w_state_nxt == S_FETCH) begin
            w_addr_nxt = r_addr + ADDR_W'(1);
        end else begin
            w_addr_nxt = '0;
        end
        if (w_state_nxt == S_OUT) begin
            if (r_state == S_OUT) begin
                w_res_idx_nxt = r_res_idx + 4'd1;
            end else begin
                w_res_idx_nxt = 4'd0;
            end
            // First beat is loaded on the same edge as the final MAC, hence w_acc_nxt.
            w_res_data_nxt = w_acc_nxt[w_res_idx_nxt];
        end else begin
            w_res_idx_nxt  = 4'd0;
            w_res_data_nxt = '0;
        end
    end

    // Address counter, read-valid delay and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_rv        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_idx   <= 4'd0;
            r_res_data  <= '0;
        end else begin
            r_addr      <= w_addr_nxt;
            r_rv        <= (r_state == S_FETCH);
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_idx   <= w_res_idx_nxt;
            r_res_data  <= w_res_data_nxt;
        end
    end

    // Accumulators: cleared when a pass is accepted, otherwise take the MAC result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) r_acc[k] <= '0;
        end else if (r_state == S_IDLE && w_state_nxt == S_FETCH) begin
            for (int k = 0; k < N_OUT; k++) r_acc[k] <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) r_acc[k] <= w_acc_nxt[k];
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.w7_raddr  = r_addr;
    assign bus.x_raddr   = r_addr;
    assign bus.res_valid = r_res_valid;
    assign bus.res_idx   = r_res_idx;
    assign bus.res_data  = r_res_data;
endmodule

// File: tb/tb_fc7_weight_reader.sv
// Directed bench for fc7_weight_reader: table of weight/activation patterns
// with hand-computed scores, plus start-while-busy and mid-pass reset sequences.
module tb_fc7_weight_reader;
    localparam int N = 84;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fc7_weight_reader_if bus ();

    fc7_weight_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models with one-cycle read latency.
    logic [7:0] wmem [N][10];
    logic [7:0] xmem [N];
    logic [7:0] wr [10];
    logic [7:0] xr;

    always @(posedge clk) begin
        for (int k = 0; k < 10; k++) begin
            if (bus.w7_raddr < 7'd84) wr[k] <= wmem[bus.w7_raddr][k];
            else wr[k] <= 8'd0;
        end
        if (bus.x_raddr < 7'd84) xr <= xmem[bus.x_raddr];
        else xr <= 8'd0;
    end

    assign bus.w7_1_rdata  = wr[0];
    assign bus.w7_2_rdata  = wr[1];
    assign bus.w7_3_rdata  = wr[2];
    assign bus.w7_4_rdata  = wr[3];
    assign bus.w7_5_rdata  = wr[4];
    assign bus.w7_6_rdata  = wr[5];
    assign bus.w7_7_rdata  = wr[6];
    assign bus.w7_8_rdata  = wr[7];
    assign bus.w7_9_rdata  = wr[8];
    assign bus.w7_10_rdata = wr[9];
    assign bus.x_rdata     = xr;

    typedef struct {
        logic [7:0] wc;     // constant weight (when not ramp)
        logic [7:0] xc;     // constant activation (when not ramp)
        bit         ramp;   // lane k weight = k+1, x[i] = i
        int         base;   // expected score of neuron 0
        int         step;   // expected increment per neuron index
        bit         extra;  // pulse start at T+5 and in DONE
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input int c, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, c, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 10; k++) wmem[i][k] = v.ramp ? 8'(k + 1) : v.wc;
            xmem[i] = v.ramp ? 8'(i) : v.xc;
        end
    endtask

    task automatic chk_all_zero(input string nm, input int c);
        chk({nm, "_busy"}, c, bus.busy, 0);
        chk({nm, "_done"}, c, bus.done, 0);
        chk({nm, "_valid"}, c, bus.res_valid, 0);
        chk({nm, "_waddr"}, c, bus.w7_raddr, 0);
        chk({nm, "_xaddr"}, c, bus.x_raddr, 0);
        chk({nm, "_idx"}, c, bus.res_idx, 0);
        chk({nm, "_data"}, c, $signed(bus.res_data), 0);
    endtask

    // One full pass; called at a negedge, start accepted at the next posedge (T).
    task automatic run_pass(input int base, input int step, input bit extra);
        bit vld;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 97; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            vld = (c >= 86) && (c <= 95);
            chk("busy", c, bus.busy, (c <= 96) ? 1 : 0);
            chk("w7_raddr", c, bus.w7_raddr, (c <= 84) ? c - 1 : 0);
            chk("x_raddr", c, bus.x_raddr, (c <= 84) ? c - 1 : 0);
            chk("res_valid", c, bus.res_valid, vld ? 1 : 0);
            chk("res_idx", c, bus.res_idx, vld ? c - 86 : 0);
            chk("res_data", c, $signed(bus.res_data), vld ? base + (c - 86) * step : 0);
            chk("done", c, bus.done, (c == 96) ? 1 : 0);
            if (extra && (c == 5 || c == 96)) bus.start = 1'b1;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;

        vt[0] = '{8'h01, 8'h01, 1'b0, 84, 0, 1'b0};
        vt[1] = '{8'h00, 8'h00, 1'b1, 3486, 3486, 1'b0};
        vt[2] = '{8'h80, 8'h80, 1'b0, 1376256, 0, 1'b0};
        vt[3] = '{8'h7F, 8'h80, 1'b0, -1365504, 0, 1'b0};
        vt[4] = '{8'h01, 8'h01, 1'b0, 84, 0, 1'b1};
        vt[5] = '{8'hFF, 8'h05, 1'b0, -420, 0, 1'b0};

        load(vt[0]);
        repeat (3) @(negedge clk);
        chk_all_zero("reset", 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("idle", 0);

        // Table passes run back to back: each start lands in the first IDLE cycle.
        for (int v = 0; v < 6; v++) begin
            load(vt[v]);
            run_pass(vt[v].base, vt[v].step, vt[v].extra);
        end

        // Reset in the middle of FETCH abandons the pass.
        load(vt[1]);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c < 40; c++) @(negedge clk);
        chk("pre_rst_busy", 39, bus.busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_all_zero("mid_rst", 40);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("post_rst_valid", c, bus.res_valid, 0);
            chk("post_rst_done", c, bus.done, 0);
            chk("post_rst_busy", c, bus.busy, 0);
        end

        // Fresh pass after reset must not carry stale accumulation.
        run_pass(vt[1].base, vt[1].step, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
